// File: rtl/sysid_reader_pkg.sv
`default_nettype none
// sysid_reader_pkg: shared FSM states, Avalon word addresses and stall-counter width.
package sysid_reader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;
    localparam int   STALL_W = 16;

endpackage
`default_nettype wire

// File: rtl/sysid_stall_timer.sv
`default_nettype none
// sysid_stall_timer: counts stalled cycles of one read; expired flags the stall
// cycle that brings the count up to limit.
module sysid_stall_timer
    import sysid_reader_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [STALL_W-1:0] limit,
    output logic               expired
);

    logic [STALL_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + STALL_W'(1);
        end
    end

    // One extra bit so a limit of 65535 cannot wrap the comparison.
    assign expired = enable && (({1'b0, count} + (STALL_W+1)'(1)) >= {1'b0, limit});

endmodule
`default_nettype wire

// File: rtl/sysid_reader.sv
`default_nettype none
// sysid_reader: reads the system-ID and timestamp words over Avalon-MM and
// reports whether the ID matches EXPECTED_ID, aborting on an excessive stall.
module sysid_reader
    import sysid_reader_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] timestamp,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        timeout
);

    localparam logic [STALL_W-1:0] LIMIT = STALL_W'(TIMEOUT_CYCLES);

    state_t      state, state_nx;
    logic [1:0]  sync;
    logic        auto_pend, auto_nx;
    logic        read_nx, addr_nx, done_nx, id_ok_nx, timeout_nx;
    logic [31:0] id_nx, ts_nx;
    logic        launch, expired;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], 1'b1};
        end
    end

    assign launch = sync[1] && (start || auto_pend);
    assign busy   = (state != IDLE);

    // Counter restarts whenever no read is outstanding, i.e. on entry to each read.
    sysid_stall_timer u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!avm_read),
        .enable  (avm_read && avm_waitrequest),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            auto_pend   <= AUTO_START;
            avm_read    <= 1'b0;
            avm_address <= ADDR_ID;
            id_value    <= '0;
            timestamp   <= '0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nx;
            auto_pend   <= auto_nx;
            avm_read    <= read_nx;
            avm_address <= addr_nx;
            id_value    <= id_nx;
            timestamp   <= ts_nx;
            done        <= done_nx;
            id_ok       <= id_ok_nx;
            timeout     <= timeout_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        auto_nx    = auto_pend;
        read_nx    = avm_read;
        addr_nx    = avm_address;
        id_nx      = id_value;
        ts_nx      = timestamp;
        done_nx    = 1'b0;
        id_ok_nx   = id_ok;
        timeout_nx = timeout;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nx = RD_ID;
                    auto_nx  = 1'b0;
                    read_nx  = 1'b1;
                    addr_nx  = ADDR_ID;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    id_nx    = avm_readdata;
                    read_nx  = 1'b0;
                    state_nx = RD_TS;
                end else if (expired) begin
                    read_nx    = 1'b0;
                    timeout_nx = 1'b1;
                    id_ok_nx   = 1'b0;
                    done_nx    = 1'b1;
                    state_nx   = IDLE;
                end
            end
            RD_TS: begin
                // First RD_TS cycle is the mandatory idle gap between transfers.
                if (!avm_read) begin
                    read_nx = 1'b1;
                    addr_nx = ADDR_TS;
                end else if (!avm_waitrequest) begin
                    ts_nx    = avm_readdata;
                    read_nx  = 1'b0;
                    state_nx = FINISH;
                end else if (expired) begin
                    read_nx    = 1'b0;
                    timeout_nx = 1'b1;
                    id_ok_nx   = 1'b0;
                    done_nx    = 1'b1;
                    state_nx   = IDLE;
                end
            end
            FINISH: begin
                done_nx    = 1'b1;
                id_ok_nx   = (id_value == EXPECTED_ID);
                timeout_nx = 1'b0;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sysid_reader.sv
`default_nettype none
// tb_sysid_reader: scoreboard bench for sysid_reader against a behavioural Avalon slave.
module tb_sysid_reader;

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        logic        ok;
        logic        to;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read, busy, done, id_ok, timeout;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata, id_value, timestamp;

    logic [31:0] id_word = '0;
    logic [31:0] ts_word = '0;
    int          wait_cycles = 0;
    bit          stuck_ts = 1'b0;
    int          served = 0;
    int          checks = 0;
    int          failures = 0;
    int          proto_err = 0;
    int          ts_rd = 0;
    bit          mon_en = 1'b1;
    logic        prev_read = 1'b0, prev_addr = 1'b0, prev_wr = 1'b0;

    sysid_reader #(
        .EXPECTED_ID    (32'h0000_0000),
        .TIMEOUT_CYCLES (4),
        .AUTO_START     (1'b1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .id_value        (id_value),
        .timestamp       (timestamp),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .timeout         (timeout)
    );

    always #5 clock = ~clock;

    // Slave: stalls the first wait_cycles cycles of every read, or forever on the timestamp word.
    assign avm_readdata    = avm_address ? ts_word : id_word;
    assign avm_waitrequest = avm_read && ((stuck_ts && avm_address) || (served < wait_cycles));

    always @(posedge clock) served <= (avm_read && avm_waitrequest) ? served + 1 : 0;

    always @(negedge clock) begin
        if (mon_en && reset_n && prev_read) begin
            if (prev_wr && (avm_read !== 1'b1 || avm_address !== prev_addr)) proto_err++;
            if (avm_read === 1'b1 && avm_address !== prev_addr) proto_err++;
        end
        if (avm_read === 1'b1 && avm_address === 1'b1) ts_rd++;
        prev_read = avm_read;
        prev_addr = avm_address;
        prev_wr   = avm_waitrequest;
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (1) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            start = 1'b0;
            if (done === 1'b1) break;
            if (lat >= 200) begin
                checks++; failures++;
                $display("FAIL done_wait: no done pulse after %0d cycles", lat);
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat; exp_t e;
        id_word = 32'h0000_0000; ts_word = 32'h1234_5678; wait_cycles = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if ({avm_read, avm_address, busy, done, id_ok, timeout} !== 6'b0) begin failures++;
            $display("FAIL reset_ctrl: got %b want 000000", {avm_read, avm_address, busy, done, id_ok, timeout}); end
        checks++; if (id_value !== 32'h0) begin failures++; $display("FAIL reset_id: got %h want 0", id_value); end
        checks++; if (timestamp !== 32'h0) begin failures++; $display("FAIL reset_ts: got %h want 0", timestamp); end
        sb.push_back('{32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, 7});
        reset_n = 1'b1;
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL auto_lat: got %0d want %0d", lat, e.lat); end
        checks++; if (id_value !== e.id) begin failures++; $display("FAIL auto_id: got %h want %h", id_value, e.id); end
        checks++; if (timestamp !== e.ts) begin failures++; $display("FAIL auto_ts: got %h want %h", timestamp, e.ts); end
        checks++; if ({id_ok, timeout} !== {e.ok, e.to}) begin failures++; $display("FAIL auto_flags: got %b want %b", {id_ok, timeout}, {e.ok, e.to}); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL auto_pulse: done got %b want 0", done); end
    endtask

    task automatic test_bad_id();
        int lat; exp_t e;
        id_word = 32'hDEAD_BEEF; ts_word = 32'hCAFE_0001;
        sb.push_back('{32'hDEAD_BEEF, 32'hCAFE_0001, 1'b0, 1'b0, 5});
        start = 1'b1;
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL bad_lat: got %0d want %0d", lat, e.lat); end
        checks++; if (id_value !== e.id) begin failures++; $display("FAIL bad_id: got %h want %h", id_value, e.id); end
        checks++; if (timestamp !== e.ts) begin failures++; $display("FAIL bad_ts: got %h want %h", timestamp, e.ts); end
        checks++; if ({id_ok, timeout} !== {e.ok, e.to}) begin failures++; $display("FAIL bad_flags: got %b want %b", {id_ok, timeout}, {e.ok, e.to}); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL bad_pulse: done got %b want 0", done); end
    endtask

    task automatic test_stall();
        int lat; exp_t e;
        id_word = 32'h0000_0000; ts_word = 32'h55AA_0F0F; wait_cycles = 3; proto_err = 0;
        sb.push_back('{32'h0000_0000, 32'h55AA_0F0F, 1'b1, 1'b0, 11});
        start = 1'b1;
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL stall_lat: got %0d want %0d", lat, e.lat); end
        checks++; if (id_value !== e.id || timestamp !== e.ts) begin failures++;
            $display("FAIL stall_data: got %h/%h want %h/%h", id_value, timestamp, e.id, e.ts); end
        checks++; if ({id_ok, timeout} !== {e.ok, e.to}) begin failures++; $display("FAIL stall_flags: got %b want %b", {id_ok, timeout}, {e.ok, e.to}); end
        checks++; if (proto_err !== 0) begin failures++; $display("FAIL stall_protocol: got %0d violations want 0", proto_err); end
        wait_cycles = 0;
    endtask

    task automatic test_timeout();
        int lat; exp_t e;
        mon_en = 1'b0; stuck_ts = 1'b1;
        id_word = 32'h0000_0000; ts_word = 32'hBBBB_BBBB;
        sb.push_back('{32'h0000_0000, 32'h55AA_0F0F, 1'b0, 1'b1, 7});
        ts_rd = 0;
        start = 1'b1;
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL to_lat: got %0d want %0d", lat, e.lat); end
        checks++; if (ts_rd !== 4) begin failures++; $display("FAIL to_read_cycles: got %0d want 4", ts_rd); end
        checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL to_read_drop: got %b want 0", avm_read); end
        checks++; if (timestamp !== e.ts) begin failures++; $display("FAIL to_ts_kept: got %h want %h", timestamp, e.ts); end
        checks++; if ({id_ok, timeout} !== {e.ok, e.to}) begin failures++; $display("FAIL to_flags: got %b want %b", {id_ok, timeout}, {e.ok, e.to}); end
        stuck_ts = 1'b0;
        @(negedge clock);
        mon_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat, n, extra; exp_t e;
        id_word = 32'h0000_0000; ts_word = 32'h0000_1111;
        sb.push_back('{32'h0000_0000, 32'h0000_1111, 1'b1, 1'b0, 0});
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(avm_read === 1'b1 && avm_address === 1'b1) && n < 20) begin @(negedge clock); n++; end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_in_rd_ts: got %b want 1", busy); end
        start = 1'b1;
        wait_done(lat);
        e = sb.pop_front();
        checks++; if ({timestamp, id_ok, timeout} !== {e.ts, e.ok, e.to}) begin failures++;
            $display("FAIL b2b_first: got %h/%b want %h/%b", timestamp, {id_ok, timeout}, e.ts, {e.ok, e.to}); end
        // Restart on the done cycle, then confirm the mid-sequence start was not queued.
        ts_word = 32'h0000_2222;
        sb.push_back('{32'h0000_0000, 32'h0000_2222, 1'b1, 1'b0, 5});
        start = 1'b1;
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL b2b_lat: got %0d want %0d", lat, e.lat); end
        checks++; if (timestamp !== e.ts) begin failures++; $display("FAIL b2b_ts: got %h want %h", timestamp, e.ts); end
        extra = 0;
        repeat (8) begin @(negedge clock); if (busy !== 1'b0 || avm_read !== 1'b0) extra++; end
        checks++; if (extra !== 0) begin failures++; $display("FAIL start_queued: got %0d busy cycles want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int lat; exp_t e;
        wait_cycles = 3; id_word = 32'h0000_0000;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++; if ({avm_read, avm_address, avm_waitrequest} !== 3'b101) begin failures++;
            $display("FAIL mid_in_rd_id: got %b want 101", {avm_read, avm_address, avm_waitrequest}); end
        reset_n = 1'b0;
        #1;
        checks++; if ({avm_read, avm_address, busy, done, id_ok, timeout} !== 6'b0) begin failures++;
            $display("FAIL mid_reset_ctrl: got %b want 000000", {avm_read, avm_address, busy, done, id_ok, timeout}); end
        checks++; if (id_value !== 32'h0 || timestamp !== 32'h0) begin failures++;
            $display("FAIL mid_reset_data: got %h/%h want 0/0", id_value, timestamp); end
        wait_cycles = 0; ts_word = 32'h7777_0001;
        sb.push_back('{32'h0000_0000, 32'h7777_0001, 1'b1, 1'b0, 7});
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL rerun_lat: got %0d want %0d", lat, e.lat); end
        checks++; if ({id_value, timestamp} !== {e.id, e.ts}) begin failures++;
            $display("FAIL rerun_data: got %h/%h want %h/%h", id_value, timestamp, e.id, e.ts); end
        checks++; if ({id_ok, timeout} !== {e.ok, e.to}) begin failures++; $display("FAIL rerun_flags: got %b want %b", {id_ok, timeout}, {e.ok, e.to}); end
    endtask

    initial begin
        test_reset();
        test_bad_id();
        test_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
